unrotate_xor_pipe: RTL and testbench

//  Decode side of the XOR-then-rotate datapath. It takes an encoded word F, the key word B,
//  the rotate amount K and the direction flag `right` used by the encoder, and recovers
//  A = rot(F, K, opposite dir) ^ B.
//  - 3-stage pipeline with a valid/ready handshake on both sides; sits between link receiver and consumer.
//  - One word per cycle throughput when not stalled.

---
 rtl/rotate_pkg.sv | 30 +++
 rtl/rot_stage.sv | 44 ++++
 rtl/unrotate_xor_pipe.sv | 79 +++++++
 tb/tb_unrotate_xor_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared rotate helpers, constants and the stage payload used by the XOR/rotate
// encoder and by the unrotate decode pipeline.
package rotate_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [WIDTH-1:0]   key;
    logic [SHAMT_W-1:0] shamt;
    logic               dir;
  } stage_t;

  // Rotates via a doubled word so the bits shifted out re-enter at the other end.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] word,
                                            input logic [SHAMT_W-1:0] amt);
    logic [2*WIDTH-1:0] dbl;
    dbl = {word, word} << amt;
    return dbl[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] word,
                                            input logic [SHAMT_W-1:0] amt);
    logic [2*WIDTH-1:0] dbl;
    dbl = {word, word} >> amt;
    return dbl[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/rot_stage.sv
// One pipeline register preceded by the power-of-two rotate steps enabled in STEPS_MASK.
// dir = 1 means the encoder rotated right, so this stage rotates left (and vice versa).
module rot_stage
  import rotate_pkg::*;
#(
  parameter logic [SHAMT_W-1:0] STEPS_MASK = '1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_load,
  input  logic   i_valid,
  input  stage_t i_stage,
  output logic   o_valid,
  output stage_t o_stage
);

  stage_t w_stage;
  stage_t r_stage;
  logic   r_valid;

  always_comb begin
    w_stage = i_stage;
    for (int s = 0; s < SHAMT_W; s++) begin
      if (STEPS_MASK[s] && i_stage.shamt[s]) begin
        w_stage.data = i_stage.dir ? rotl(w_stage.data, SHAMT_W'(1 << s))
                                   : rotr(w_stage.data, SHAMT_W'(1 << s));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_stage <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_stage <= w_stage;
    end
  end

  assign o_valid = r_valid;
  assign o_stage = r_stage;

endmodule

// File: rtl/unrotate_xor_pipe.sv
// Decode side of the XOR-then-rotate link: A = rot(F, K, opposite dir) ^ B over a
// 3-stage pipeline (S1: 16/8-bit steps, S2: 4/2/1-bit steps, S3: XOR + output register).
//
// Handshake: a beat moves on in_valid & in_ready at the input and on out_valid & out_ready
// at the output. Stage i loads when it is empty or stage i+1 loads; the output stage
// loads when empty or out_ready. in_ready is the S1 load term, so it depends on out_ready
// and the stage valids but never on in_valid.
module unrotate_xor_pipe
  import rotate_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   F,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] K,
  input  logic               right,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   A
);

  stage_t           w_s0;
  stage_t           w_s1;
  stage_t           w_s2;
  logic             w_v1;
  logic             w_v2;
  logic             w_load1;
  logic             w_load2;
  logic             w_load3;
  logic             w_unused_s2;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;

  assign w_load3  = !r_out_valid || out_ready;
  assign w_load2  = !w_v2 || w_load3;
  assign w_load1  = !w_v1 || w_load2;
  assign in_ready = w_load1;

  assign w_s0 = '{data: F, key: B, shamt: K, dir: right};

  rot_stage #(.STEPS_MASK(5'b11000)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load1),
    .i_valid (in_valid),
    .i_stage (w_s0),
    .o_valid (w_v1),
    .o_stage (w_s1)
  );

  rot_stage #(.STEPS_MASK(5'b00111)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load2),
    .i_valid (w_v1),
    .i_stage (w_s1),
    .o_valid (w_v2),
    .o_stage (w_s2)
  );

  // Rotation is complete after S2, so its shift amount and direction go no further.
  assign w_unused_s2 = ^{w_s2.shamt, w_s2.dir};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_a         <= '0;
    end else if (w_load3) begin
      r_out_valid <= w_v2;
      if (w_v2) r_a <= w_s2.data ^ w_s2.key;
    end
  end

  assign out_valid = r_out_valid;
  assign A         = r_a;

endmodule

// File: tb/tb_unrotate_xor_pipe.sv
// Bench for unrotate_xor_pipe: directed vectors, backpressure, mid-stream reset and a
// random encode/decode round trip against an index-arithmetic reference model.
module tb_unrotate_xor_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] F;
  logic [31:0] B;
  logic [4:0]  K;
  logic        right;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;

  always #5 clk = ~clk;

  unrotate_xor_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .F         (F),
    .B         (B),
    .K         (K),
    .right     (right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A)
  );

  int          total = 0;
  int          bad = 0;
  int          out_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp;
  logic [31:0] last_a;
  logic [31:0] a_hold;
  bit          got_in;
  bit          got_out;

  // Reference rotations by explicit bit index arithmetic.
  function automatic logic [31:0] ref_rotl(input logic [31:0] w, input int k);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[(i + k) % 32] = w[i];
    return r;
  endfunction

  function automatic logic [31:0] ref_rotr(input logic [31:0] w, input int k);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[(i + k) % 32];
    return r;
  endfunction

  function automatic logic [31:0] ref_decode(input logic [31:0] f, input logic [31:0] b,
                                             input int k, input logic r);
    return (r ? ref_rotl(f, k) : ref_rotr(f, k)) ^ b;
  endfunction

  function automatic logic [31:0] ref_encode(input logic [31:0] a, input logic [31:0] b,
                                             input int k, input logic r);
    return r ? ref_rotr(a ^ b, k) : ref_rotl(a ^ b, k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] f, input logic [31:0] b, input logic [4:0] k,
                       input logic r);
    F = f; B = b; K = k; right = r;
    cur_exp  = ref_decode(f, b, int'(k), r);
    in_valid = 1'b1;
  endtask

  task automatic drive_rt(input logic [31:0] a, input logic [31:0] b, input logic [4:0] k,
                          input logic r);
    F = ref_encode(a, b, int'(k), r); B = b; K = k; right = r;
    cur_exp = a;
  endtask

  // One clock: observe both handshakes mid-cycle, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    got_in  = 1'b0;
    got_out = 1'b0;
    if (out_valid && out_ready) begin
      got_out = 1'b1;
      last_a  = A;
      out_cnt++;
      if (exp_q.size() == 0) check("spurious_out", {31'b0, out_valid}, 32'd0);
      else check("out_data", A, exp_q.pop_front());
    end
    if (in_valid && in_ready) begin
      got_in = 1'b1;
      exp_q.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [31:0] f, input logic [31:0] b, input logic [4:0] k,
                          input logic r, input logic [31:0] want, input string tag);
    int lat;
    out_ready = 1'b1;
    drive(f, b, k, r);
    tick();
    in_valid = 1'b0;
    check({tag, "_accept"}, {31'b0, got_in}, 32'd1);
    lat = 0;
    while (!got_out && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd3);
    check({tag, "_value"}, last_a, want);
  endtask

  initial begin
    logic [31:0] bf[6];
    logic [31:0] bb[6];
    logic [4:0]  bk[6];
    logic        br[6];
    int          i;
    int          cyc;
    int          acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    F = '0; B = '0; K = '0; right = 1'b0; cur_exp = '0; last_a = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_a", A, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed decode vectors.
    send_vec(32'h0000_0002, 32'h0, 5'd1,  1'b0, 32'h0000_0001, "k1_dir0");
    send_vec(32'h8000_0000, 32'h0, 5'd1,  1'b1, 32'h0000_0001, "k1_dir1");
    send_vec(32'hFFFF_0000, 32'h0000_FFFF, 5'd0, 1'b0, 32'hFFFF_FFFF, "k0_dir0");
    send_vec(32'hFFFF_0000, 32'h0000_FFFF, 5'd0, 1'b1, 32'hFFFF_FFFF, "k0_dir1");
    send_vec(32'h8000_0000, 32'h0, 5'd31, 1'b0, 32'h0000_0001, "k31_dir0");
    send_vec(32'h0000_0002, 32'h0, 5'd31, 1'b1, 32'h0000_0001, "k31_dir1");

    // Backpressure: 6 beats against a stalled consumer for 5 cycles.
    for (int n = 0; n < 6; n++) begin
      bf[n] = $urandom; bb[n] = $urandom; bk[n] = 5'($urandom_range(0, 31));
      br[n] = 1'($urandom_range(0, 1));
    end
    out_cnt = 0; i = 0; out_ready = 1'b0; a_hold = '0;
    for (int c = 0; c < 5; c++) begin
      drive(bf[i], bb[i], bk[i], br[i]);
      tick();
      if (got_in) i++;
      if (c == 3) a_hold = A;
    end
    check("bp_accepts", i, 32'd3);
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    check("bp_a_stable", A, a_hold);
    check("bp_head", A, exp_q[0]);
    out_ready = 1'b1; cyc = 0;
    while ((i < 6 || exp_q.size() > 0) && cyc < 50) begin
      if (i < 6) drive(bf[i], bb[i], bk[i], br[i]);
      else in_valid = 1'b0;
      tick();
      if (got_in) i++;
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_out_count", out_cnt, 32'd6);
    check("bp_q_empty", exp_q.size(), 32'd0);

    // Reset with two beats in flight.
    out_ready = 1'b1;
    drive(32'h1234_5678, 32'h0, 5'd0, 1'b0);
    tick();
    drive(32'hA5A5_0F0F, 32'h0, 5'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("rst_pre_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_a", A, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) tick();
    check("rst_quiet", {31'b0, out_valid}, 32'd0);
    send_vec(32'h0000_0002, 32'h0, 5'd1, 1'b0, 32'h0000_0001, "post_rst");

    // Random round trip through the encoder model with random flow control.
    acc = 0; cyc = 0; out_cnt = 0;
    while (acc < 10000 && cyc < 60000) begin
      drive_rt($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      if (got_in) acc++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("rand_accepted", acc, 32'd10000);
    check("rand_delivered", out_cnt, 32'd10000);
    check("rand_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
